skyking_text_engine: RTL and testbench

SKYKING_TEXT_ENGINE -- requirements
Module: skyking_text_engine

---
 rtl/skyking_pkg.sv | 31 +++
 rtl/skyking_font_rom.sv | 65 ++++++
 rtl/skyking_text_engine.sv | 185 ++++++++++++++++++
 tb/tb_skyking_text_engine.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/skyking_pkg.sv
// Shared types and constants for the SKYKING text engine: character codes,
// the message shown on screen and the sequencing states.
package skyking_pkg;

  // 5-bit character code: letters first, then the three punctuation glyphs.
  typedef enum logic [4:0] {
    CH_A, CH_B, CH_C, CH_D, CH_E, CH_F, CH_G, CH_H, CH_I, CH_J,
    CH_K, CH_L, CH_M, CH_N, CH_O, CH_P, CH_Q, CH_R, CH_S, CH_T,
    CH_U, CH_V, CH_W, CH_X, CH_Y, CH_Z, CH_SPACE, CH_BANG, CH_DASH
  } char_t;

  // Typing sequencer states.
  typedef enum logic [1:0] {
    IDLE,
    TYPE,
    HOLD,
    CLEAR
  } state_t;

  // Longest message the engine can show; shorter builds use a prefix.
  localparam int MSG_MAX = 32;

  // "SKY-KING CALLING ALL STATIONS!--"
  localparam char_t MESSAGE [MSG_MAX] = '{
    CH_S, CH_K, CH_Y, CH_DASH, CH_K, CH_I, CH_N, CH_G,
    CH_SPACE, CH_C, CH_A, CH_L, CH_L, CH_I, CH_N, CH_G,
    CH_SPACE, CH_A, CH_L, CH_L, CH_SPACE, CH_S, CH_T, CH_A,
    CH_T, CH_I, CH_O, CH_N, CH_S, CH_BANG, CH_DASH, CH_DASH
  };

endpackage

// File: rtl/skyking_font_rom.sv
// Combinational 5x7 font: one 5-bit row bitmap per (character, glyph row).
// Bit 4 of row_bits is the leftmost pixel; row 7 and unused codes are blank.
module skyking_font_rom
  import skyking_pkg::*;
(
  input  char_t      code,
  input  logic [2:0] row,
  output logic [4:0] row_bits
);

  // Whole glyph as seven 5-bit rows, top row in the most significant bits.
  logic [34:0] glyph;

  // Character code to packed glyph bitmap.
  always_comb begin
    glyph = '0;
    case (code)
      CH_A:    glyph = 35'b01110_10001_10001_11111_10001_10001_10001;
      CH_B:    glyph = 35'b11110_10001_10001_11110_10001_10001_11110;
      CH_C:    glyph = 35'b01110_10001_10000_10000_10000_10001_01110;
      CH_D:    glyph = 35'b11110_10001_10001_10001_10001_10001_11110;
      CH_E:    glyph = 35'b11111_10000_10000_11110_10000_10000_11111;
      CH_F:    glyph = 35'b11111_10000_10000_11110_10000_10000_10000;
      CH_G:    glyph = 35'b01110_10001_10000_10111_10001_10001_01111;
      CH_H:    glyph = 35'b10001_10001_10001_11111_10001_10001_10001;
      CH_I:    glyph = 35'b01110_00100_00100_00100_00100_00100_01110;
      CH_J:    glyph = 35'b00111_00010_00010_00010_00010_10010_01100;
      CH_K:    glyph = 35'b10001_10010_10100_11000_10100_10010_10001;
      CH_L:    glyph = 35'b10000_10000_10000_10000_10000_10000_11111;
      CH_M:    glyph = 35'b10001_11011_10101_10101_10001_10001_10001;
      CH_N:    glyph = 35'b10001_10001_11001_10101_10011_10001_10001;
      CH_O:    glyph = 35'b01110_10001_10001_10001_10001_10001_01110;
      CH_P:    glyph = 35'b11110_10001_10001_11110_10000_10000_10000;
      CH_Q:    glyph = 35'b01110_10001_10001_10001_10101_10010_01101;
      CH_R:    glyph = 35'b11110_10001_10001_11110_10100_10010_10001;
      CH_S:    glyph = 35'b01110_10001_10000_01110_00001_10001_01110;
      CH_T:    glyph = 35'b11111_00100_00100_00100_00100_00100_00100;
      CH_U:    glyph = 35'b10001_10001_10001_10001_10001_10001_01110;
      CH_V:    glyph = 35'b10001_10001_10001_10001_10001_01010_00100;
      CH_W:    glyph = 35'b10001_10001_10001_10101_10101_10101_01010;
      CH_X:    glyph = 35'b10001_10001_01010_00100_01010_10001_10001;
      CH_Y:    glyph = 35'b10001_10001_01010_00100_00100_00100_00100;
      CH_Z:    glyph = 35'b11111_00001_00010_00100_01000_10000_11111;
      CH_BANG: glyph = 35'b00100_00100_00100_00100_00100_00000_00100;
      CH_DASH: glyph = 35'b00000_00000_00000_11111_00000_00000_00000;
      default: glyph = '0;
    endcase
  end

  // Pick the requested row; row 7 is the blank underline row.
  always_comb begin
    row_bits = '0;
    case (row)
      3'd0:    row_bits = glyph[34:30];
      3'd1:    row_bits = glyph[29:25];
      3'd2:    row_bits = glyph[24:20];
      3'd3:    row_bits = glyph[19:15];
      3'd4:    row_bits = glyph[14:10];
      3'd5:    row_bits = glyph[9:5];
      3'd6:    row_bits = glyph[4:0];
      default: row_bits = '0;
    endcase
  end

endmodule

// File: rtl/skyking_text_engine.sv
// Typewriter-style text overlay: reveals the message one character at a time
// on vsync-derived frame ticks, holds it, clears it, and optionally loops.
// Pixel outputs are registered one clock behind the pixel coordinates.
module skyking_text_engine
  import skyking_pkg::*;
#(
  parameter int N_CHARS         = 16,
  parameter int SCALE           = 1,
  parameter int X0              = 64,
  parameter int Y0              = 416,
  parameter int FRAMES_PER_CHAR = 4,
  parameter int HOLD_FRAMES     = 120,
  parameter int BLINK_FRAMES    = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       vsync,
  input  logic       video_active,
  input  logic [9:0] pix_x,
  input  logic [9:0] pix_y,
  input  logic       start,
  input  logic       loop_en,
  output logic       text_on,
  output logic       cursor_on,
  output logic       busy
);

  localparam logic signed [10:0] X0_S       = 11'(X0);
  localparam logic signed [10:0] Y0_S       = 11'(Y0);
  localparam logic [9:0]         CELL_W     = 10'(8 << SCALE);
  localparam logic [9:0]         N_CHARS_W  = 10'(N_CHARS);
  localparam logic [5:0]         N_CHARS_R  = 6'(N_CHARS);
  localparam logic [7:0]         FPC_LAST   = 8'(FRAMES_PER_CHAR - 1);
  localparam logic [7:0]         HOLD_LAST  = 8'(HOLD_FRAMES - 1);
  localparam logic [7:0]         BLINK_LAST = 8'(BLINK_FRAMES - 1);

  state_t      state_q, state_d;
  logic        vsync_q, vsync_d;
  logic [5:0]  revealed_q, revealed_d;
  logic [7:0]  frame_cnt_q, frame_cnt_d;
  logic [7:0]  blink_cnt_q, blink_cnt_d;
  logic        blink_q, blink_d;
  logic        text_on_q, text_on_d;
  logic        cursor_on_q, cursor_on_d;

  logic        frame_tick;
  logic        enter_type;

  logic signed [10:0] dx, dy;
  logic [9:0]  col;
  logic [9:0]  cursor_col;
  logic [2:0]  glyph_row, glyph_col;
  logic        in_row, x_ok;
  char_t       cur_char;
  logic [4:0]  row_bits;
  logic [7:0]  row_ext;

  // One-cycle pulse on each rising edge of vsync.
  assign frame_tick = vsync & ~vsync_q;
  assign enter_type = (state_d == TYPE) && (state_q != TYPE);

  assign busy      = (state_q != IDLE);
  assign text_on   = text_on_q;
  assign cursor_on = cursor_on_q;

  // All state registers, synchronously reset to an idle, blank display.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      vsync_q     <= 1'b0;
      revealed_q  <= '0;
      frame_cnt_q <= '0;
      blink_cnt_q <= '0;
      blink_q     <= 1'b1;
      text_on_q   <= 1'b0;
      cursor_on_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      vsync_q     <= vsync_d;
      revealed_q  <= revealed_d;
      frame_cnt_q <= frame_cnt_d;
      blink_cnt_q <= blink_cnt_d;
      blink_q     <= blink_d;
      text_on_q   <= text_on_d;
      cursor_on_q <= cursor_on_d;
    end
  end

  // Sequencer: the frame counter is cleared on every state change, so a tick
  // that causes a transition is never also counted by the state it enters.
  always_comb begin
    state_d     = state_q;
    vsync_d     = vsync;
    revealed_d  = revealed_q;
    frame_cnt_d = frame_cnt_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d     = TYPE;
          revealed_d  = '0;
          frame_cnt_d = '0;
        end
      end
      TYPE: begin
        if (frame_tick) begin
          if (frame_cnt_q == FPC_LAST) begin
            frame_cnt_d = '0;
            revealed_d  = revealed_q + 6'd1;
            if (revealed_q + 6'd1 == N_CHARS_R) begin
              state_d = HOLD;
            end
          end else begin
            frame_cnt_d = frame_cnt_q + 8'd1;
          end
        end
      end
      HOLD: begin
        if (frame_tick) begin
          if (frame_cnt_q == HOLD_LAST) begin
            state_d     = CLEAR;
            frame_cnt_d = '0;
          end else begin
            frame_cnt_d = frame_cnt_q + 8'd1;
          end
        end
      end
      CLEAR: begin
        revealed_d  = '0;
        frame_cnt_d = '0;
        state_d     = loop_en ? TYPE : IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Cursor blink phase: restarts lit on every entry to TYPE, then toggles
  // every BLINK_FRAMES ticks while the message is being typed or held.
  always_comb begin
    blink_d     = blink_q;
    blink_cnt_d = blink_cnt_q;
    if (enter_type) begin
      blink_d     = 1'b1;
      blink_cnt_d = '0;
    end else if ((state_q == TYPE || state_q == HOLD) && frame_tick) begin
      if (blink_cnt_q == BLINK_LAST) begin
        blink_cnt_d = '0;
        blink_d     = ~blink_q;
      end else begin
        blink_cnt_d = blink_cnt_q + 8'd1;
      end
    end
  end

  // Pixel to character-cell geometry; a negative offset means left of or
  // above the text row.
  always_comb begin
    dx        = $signed({1'b0, pix_x}) - X0_S;
    dy        = $signed({1'b0, pix_y}) - Y0_S;
    x_ok      = ~dx[10];
    in_row    = ~dy[10] && (dy[9:0] < CELL_W);
    col       = dx[9:0] >> (3 + SCALE);
    glyph_row = dy[SCALE +: 3];
    glyph_col = dx[SCALE +: 3];
    cur_char  = MESSAGE[col[4:0]];
  end

  skyking_font_rom u_font_rom (
    .code     (cur_char),
    .row      (glyph_row),
    .row_bits (row_bits)
  );

  // Next-pixel text and cursor decisions; glyph columns 5..7 read as blank.
  always_comb begin
    row_ext     = {row_bits, 3'b000};
    cursor_col  = (state_q == HOLD) ? N_CHARS_W : {4'b0000, revealed_q};
    text_on_d   = video_active && in_row && x_ok &&
                  (col < {4'b0000, revealed_q}) &&
                  row_ext[3'd7 - glyph_col];
    cursor_on_d = video_active && in_row && x_ok &&
                  (state_q == TYPE || state_q == HOLD) &&
                  blink_q && (col == cursor_col) && (glyph_row == 3'd7);
  end

endmodule

// File: tb/tb_skyking_text_engine.sv
// Self-checking bench for skyking_text_engine: directed sequencing steps
// followed by randomized frames and pixels against a frame-count model.
module tb_skyking_text_engine;
  import skyking_pkg::*;

  localparam int TB_N     = 4;
  localparam int TB_FPC   = 2;
  localparam int TB_HOLD  = 3;
  localparam int TB_BLINK = 1;
  localparam int TB_X0    = 64;
  localparam int TB_Y0    = 416;

  // Reference glyphs for the first four message characters "SKY-".
  localparam logic [34:0] M_GLYPH [4] = '{
    35'b01110_10001_10000_01110_00001_10001_01110,
    35'b10001_10010_10100_11000_10100_10010_10001,
    35'b10001_10001_01010_00100_00100_00100_00100,
    35'b00000_00000_00000_11111_00000_00000_00000
  };

  logic       clk = 1'b0;
  logic       rst_n;
  logic       vsync;
  logic       video_active;
  logic [9:0] pix_x, pix_y;
  logic       start;
  logic       loop_en;
  logic       text_on, cursor_on, busy;

  int n_asserts  = 0;
  int n_failures = 0;

  // Model: whether a message is running and ticks since it last entered TYPE.
  bit m_active = 1'b0;
  int m_ticks  = 0;

  skyking_text_engine #(
    .N_CHARS         (TB_N),
    .SCALE           (0),
    .X0              (TB_X0),
    .Y0              (TB_Y0),
    .FRAMES_PER_CHAR (TB_FPC),
    .HOLD_FRAMES     (TB_HOLD),
    .BLINK_FRAMES    (TB_BLINK)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .vsync        (vsync),
    .video_active (video_active),
    .pix_x        (pix_x),
    .pix_y        (pix_y),
    .start        (start),
    .loop_en      (loop_en),
    .text_on      (text_on),
    .cursor_on    (cursor_on),
    .busy         (busy)
  );

  // 100 MHz pixel clock.
  always #5 clk = ~clk;

  // Hard stop in case the sequence ever stalls.
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic int modelRevealed();
    if (!m_active) return 0;
    if (m_ticks >= TB_N * TB_FPC) return TB_N;
    return m_ticks / TB_FPC;
  endfunction

  function automatic state_t modelState();
    if (!m_active) return IDLE;
    if (m_ticks < TB_N * TB_FPC) return TYPE;
    return HOLD;
  endfunction

  function automatic bit modelBlink();
    return ((m_ticks / TB_BLINK) % 2) == 0;
  endfunction

  function automatic bit modelText(int x, int y, bit va);
    int dx;
    int dy;
    int col;
    int gc;
    logic [34:0] g;
    dx = x - TB_X0;
    dy = y - TB_Y0;
    if (!va || dx < 0 || dy < 0 || dy >= 8) return 1'b0;
    col = dx / 8;
    gc  = dx % 8;
    if (col >= modelRevealed() || dy == 7 || gc >= 5) return 1'b0;
    g = M_GLYPH[col];
    return g[34 - 5 * dy - gc];
  endfunction

  function automatic bit modelCursor(int x, int y, bit va);
    int dx;
    dx = x - TB_X0;
    if (!va || !m_active || !modelBlink()) return 1'b0;
    if (dx < 0 || y - TB_Y0 != 7) return 1'b0;
    return (dx / 8) == modelRevealed();
  endfunction

  task automatic checkOutput(string tag, logic [31:0] observed, logic [31:0] expected);
    n_asserts++;
    assert (observed === expected)
    else begin
      n_failures++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic checkState(string tag);
    checkOutput({tag, ".state"}, 32'(dut.state_q), 32'(modelState()));
    checkOutput({tag, ".revealed"}, 32'(dut.revealed_q), 32'(modelRevealed()));
    checkOutput({tag, ".busy"}, 32'(busy), 32'(m_active));
  endtask

  // Present one pixel and check both outputs one clock later.
  task automatic applyStimulus(int x, int y, bit va);
    @(negedge clk);
    pix_x        = 10'(x);
    pix_y        = 10'(y);
    video_active = va;
    @(posedge clk);
    #1;
    checkOutput($sformatf("text_on@%0d,%0d", x, y), 32'(text_on), 32'(modelText(x, y, va)));
    checkOutput($sformatf("cursor_on@%0d,%0d", x, y), 32'(cursor_on), 32'(modelCursor(x, y, va)));
  endtask

  // One vsync rising edge; the sequencer reacts at the following clock edge.
  task automatic pulseFrame();
    @(negedge clk);
    vsync = 1'b1;
    @(posedge clk);
    #1;
    if (m_active) begin
      m_ticks++;
      if (m_ticks == TB_N * TB_FPC + TB_HOLD) begin
        checkOutput("clear_state", 32'(dut.state_q), 32'(CLEAR));
        if (loop_en) m_ticks = 0;
        else m_active = 1'b0;
      end
    end
    @(negedge clk);
    vsync = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic pulseStart();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    if (!m_active) begin
      m_active = 1'b1;
      m_ticks  = 0;
    end
  endtask

  // Frame plus a fixed set of called-out pixels and a few random ones.
  task automatic frameAndPixels(string tag);
    pulseFrame();
    checkState(tag);
    applyStimulus(64, 416, 1'b1);
    applyStimulus(65, 416, 1'b1);
    applyStimulus(72, 416, 1'b1);
    applyStimulus(80, 423, 1'b1);
    applyStimulus(80, 422, 1'b1);
    applyStimulus(88, 423, 1'b1);
    applyStimulus(96, 423, 1'b1);
    applyStimulus(65, 416, 1'b0);
    for (int i = 0; i < 3; i++) begin
      applyStimulus($urandom_range(56, 112), $urandom_range(410, 428),
                    $urandom_range(0, 3) != 0);
    end
  endtask

  initial begin
    rst_n        = 1'b0;
    start        = 1'b1;
    vsync        = 1'b0;
    video_active = 1'b0;
    pix_x        = '0;
    pix_y        = '0;
    loop_en      = 1'b0;

    // Reset held with start asserted.
    repeat (4) @(posedge clk);
    #1;
    checkOutput("reset.busy", 32'(busy), 32'd0);
    checkOutput("reset.text_on", 32'(text_on), 32'd0);
    checkOutput("reset.cursor_on", 32'(cursor_on), 32'd0);
    checkState("reset");
    @(negedge clk);
    rst_n = 1'b1;
    start = 1'b0;

    // Frames without start leave the engine idle.
    frameAndPixels("idle");

    // Start and reveal all characters, with a stray start mid-typing.
    pulseStart();
    checkState("started");
    for (int k = 1; k <= TB_N * TB_FPC; k++) begin
      frameAndPixels($sformatf("type%0d", k));
      if (k == 3) begin
        pulseStart();
        checkState("start_ignored");
      end
    end

    // Looping: the hold expires into CLEAR then straight back to TYPE.
    loop_en = 1'b1;
    for (int k = 1; k <= TB_HOLD; k++) frameAndPixels($sformatf("hold_loop%0d", k));
    checkState("looped");

    // Non-looping: full run ends in IDLE.
    loop_en = 1'b0;
    for (int k = 1; k <= TB_N * TB_FPC + TB_HOLD; k++) frameAndPixels($sformatf("run%0d", k));
    checkState("ended");

    // Reset during HOLD abandons the message.
    pulseStart();
    for (int k = 1; k <= TB_N * TB_FPC + 1; k++) frameAndPixels($sformatf("pre_rst%0d", k));
    @(negedge clk);
    rst_n        = 1'b0;
    pix_x        = 10'd65;
    pix_y        = 10'd416;
    video_active = 1'b1;
    @(posedge clk);
    #1;
    m_active = 1'b0;
    m_ticks  = 0;
    checkOutput("hold_rst.text_on", 32'(text_on), 32'(modelText(65, 416, 1'b1)));
    checkState("hold_rst");
    @(negedge clk);
    rst_n = 1'b1;
    applyStimulus(65, 416, 1'b1);
    frameAndPixels("after_rst");

    // Randomized frames, start requests and loop settings.
    for (int f = 0; f < 40; f++) begin
      if (f % 10 == 0) loop_en = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 5) == 0) begin
        pulseStart();
        checkState($sformatf("rnd_start%0d", f));
      end
      frameAndPixels($sformatf("rnd%0d", f));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_failures);
    $finish;
  end

endmodule
